button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 4: number of independent button channels (1..32).
REQ-002 Parameter CLK_HZ, default 125_000_000: frequency of clk_in in Hz.
REQ-003 Parameter DEBOUNCE_MS, default 20: stable time, in ms, needed to accept a press or a release.
REQ-004 Parameter LONG_MS, default 3000: hold time, in ms after an accepted press, that marks a long press.
REQ-005 Parameter REPEAT_MS, default 200: auto-repeat period, in ms, while a long press is held.
REQ-006 Parameter REPEAT_EN, default 1: 1 enables auto-repeat pulses; 0 disables them.
REQ-007 Parameter ACTIVE_LOW, default 0: 1 means a raw input low is "pressed"; 0 means high is "pressed".
REQ-008 clk_in  input  1  single system clock; the only clock in the block.
REQ-009 rst_n  input  1  reset, asynchronous and active-low.
REQ-010 button_in  input  N_BTN  raw asynchronous button pins, one bit per channel.
REQ-011 btn_level  output  N_BTN  debounced level; 1 = pressed.
REQ-012 click_pulse  output  N_BTN  one-cycle pulse on an accepted release of a press that never reached long.
REQ-013 long_pulse  output  N_BTN  one-cycle pulse when the hold time reaches LONG_MS.
REQ-014 repeat_pulse  output  N_BTN  one-cycle pulse every REPEAT_MS while held past long.

Function
REQ-015 Each button_in bit SHALL pass through a 2-flop synchronizer and then the ACTIVE_LOW polarity inversion, giving the synced level s.
REQ-016 A shared prescaler SHALL assert tick for one clk_in cycle every CLK_HZ/1000 cycles; no derived clocks; all timing counts ticks.
REQ-017 Each channel SHALL hold states IDLE, DB_DN, PRESSED, HELD, DB_UP, plus a counter cnt and a flag was_long; all transitions are evaluated only on tick cycles.
REQ-018 IDLE: s=1 -> DB_DN, cnt=0.
REQ-019 DB_DN: s=0 -> IDLE; else cnt++; at cnt==DEBOUNCE_MS-1 -> PRESSED, btn_level=1, cnt=0, was_long=0.
REQ-020 PRESSED: s=0 -> DB_UP, cnt=0; else cnt++; at cnt==LONG_MS-1 -> HELD, long_pulse, cnt=0, was_long=1.
REQ-021 HELD: s=0 -> DB_UP, cnt=0; else cnt++; at cnt==REPEAT_MS-1 -> repeat_pulse if REPEAT_EN, cnt=0.
REQ-022 DB_UP: s=1 -> PRESSED if was_long=0 (else HELD), cnt=0; else cnt++; at cnt==DEBOUNCE_MS-1 -> IDLE, btn_level=0, click_pulse if was_long=0.
REQ-023 Hold time is not accumulated across a bounce: a re-press from DB_UP restarts the long or repeat count from 0.
REQ-024 All outputs SHALL be registered; each pulse is high for exactly the one clk_in cycle after the tick that triggers it.
REQ-025 A single press SHALL never produce both click_pulse and long_pulse.
REQ-026 cnt width SHALL be clog2(max(DEBOUNCE_MS,LONG_MS,REPEAT_MS)+1); cnt never wraps.
REQ-027 Channels SHALL be fully independent; simultaneous events on different channels are all reported in the same cycle.
REQ-028 A press shorter than DEBOUNCE_MS ticks SHALL produce no output activity.

Reset
REQ-029 rst_n low SHALL immediately clear the synchronizers, prescaler, every state (to IDLE), cnt, was_long, and all outputs to 0.
REQ-030 Reset asserted mid-press SHALL emit no pulse; after release of reset a still-held button is treated as a fresh press.

Structure
REQ-031 Package button_pkg SHALL hold the channel state enum and the ticks-per-ms calculation function.
REQ-032 Sub-module button_channel (one channel: synchronizer plus FSM) SHALL be instantiated N_BTN times by a generate loop; the prescaler stays in the top level.

Verification (CLK_HZ=10_000, so tick every 10 cycles; DEBOUNCE_MS=5, LONG_MS=100, REPEAT_MS=20)
REQ-033 Clean press held 50 ms, then released -> btn_level rises 5 ticks (±1) after the edge; one click_pulse about 5 ticks after release; no long_pulse.
REQ-034 Press held 150 ms -> long_pulse at about 105 ticks; repeat_pulse at +20 and +40 ticks; no click_pulse on release.
REQ-035 A 3-tick glitch, and a press with a 2-tick release bounce at 30 ms -> glitch gives no activity; bounce gives no btn_level drop and no click.
REQ-036 ACTIVE_LOW=1 with N_BTN=4 and channels 0 and 3 pressed together -> both btn_level bits rise in the same cycle; channels 1 and 2 stay 0.
REQ-037 rst_n pulled low at 60 ms into a hold -> all outputs 0 at once; with the button still held after reset, long_pulse comes 105 ticks after reset release.
REQ-038 REPEAT_EN=0 with a 200 ms hold -> exactly one long_pulse and zero repeat_pulse.

Source files
------------

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types and constant helpers for the button conditioner.
//   btn_state_e    : per-channel debounce / hold state (also visible on debug)
//   ticks_per_ms   : prescaler divide ratio for a given clock frequency
//   cnt_width      : width of the per-channel timing counter
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DB_DN   = 3'd1,
        ST_PRESSED = 3'd2,
        ST_HELD    = 3'd3,
        ST_DB_UP   = 3'd4
    } btn_state_e;

    // Clock cycles per millisecond, never below 1 so the prescaler stays legal
    // for very slow simulation clocks.
    function automatic int ticks_per_ms(input int clk_hz);
        int t;
        t = clk_hz / 1000;
        if (t < 1) t = 1;
        return t;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

    // Wide enough to hold the largest terminal count, so cnt never wraps.
    function automatic int cnt_width(input int debounce_ms, input int long_ms,
                                     input int repeat_ms);
        return $clog2(max3(debounce_ms, long_ms, repeat_ms) + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One button: 2-flop synchronizer, polarity fix, debounce / long-press /
// auto-repeat state machine. All timing advances only on tick_i (1 ms).
// Ports:
//   clk_in, rst_n  : clock, async active-low reset
//   tick_i         : 1-cycle strobe once per millisecond
//   button_i       : raw asynchronous pin
//   level_o        : debounced level, 1 = pressed
//   click_o        : 1-cycle pulse on release of a short press
//   long_o         : 1-cycle pulse when the hold reaches the long time
//   repeat_o       : 1-cycle pulse every repeat period while held past long
//   state_o        : current FSM state (debug)
// -----------------------------------------------------------------------------
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 3000,
    parameter int REPEAT_MS   = 200,
    parameter int REPEAT_EN   = 1,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic       button_i,
    output logic       level_o,
    output logic       click_o,
    output logic       long_o,
    output logic       repeat_o,
    output logic [2:0] state_o
);

    localparam int CW = cnt_width(DEBOUNCE_MS, LONG_MS, REPEAT_MS);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_MS - 1);
    localparam logic [CW-1:0] LNG_LAST = CW'(LONG_MS - 1);
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_MS - 1);

    logic [1:0]    sync_q;
    btn_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          was_long_q;
    logic          level_q;
    logic          click_q;
    logic          long_q;
    logic          repeat_q;
    logic          s;

    // Synced level with polarity folded in: 1 always means "pressed".
    assign s = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            was_long_q <= 1'b0;
            level_q    <= 1'b0;
            click_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], button_i};
            // Pulses default low so each is exactly one cycle wide.
            click_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            if (tick_i) begin
                case (state_q)
                    ST_IDLE: begin
                        if (s) begin
                            state_q <= ST_DB_DN;
                            cnt_q   <= '0;
                        end
                    end
                    ST_DB_DN: begin
                        if (!s) begin
                            state_q <= ST_IDLE;
                        end else if (cnt_q == DB_LAST) begin
                            state_q    <= ST_PRESSED;
                            level_q    <= 1'b1;
                            cnt_q      <= '0;
                            was_long_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_PRESSED: begin
                        if (!s) begin
                            state_q <= ST_DB_UP;
                            cnt_q   <= '0;
                        end else if (cnt_q == LNG_LAST) begin
                            state_q    <= ST_HELD;
                            long_q     <= 1'b1;
                            cnt_q      <= '0;
                            was_long_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_HELD: begin
                        if (!s) begin
                            state_q <= ST_DB_UP;
                            cnt_q   <= '0;
                        end else if (cnt_q == REP_LAST) begin
                            repeat_q <= (REPEAT_EN != 0);
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_DB_UP: begin
                        // A bounce back to pressed restarts the hold count; the
                        // was_long flag decides which hold phase we resume.
                        if (s) begin
                            state_q <= was_long_q ? ST_HELD : ST_PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= ST_IDLE;
                            level_q <= 1'b0;
                            click_q <= ~was_long_q;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign level_o  = level_q;
    assign click_o  = click_q;
    assign long_o   = long_q;
    assign repeat_o = repeat_q;
    assign state_o  = state_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// N_BTN independent button channels sharing one millisecond prescaler.
// Ports:
//   clk_in        : system clock (only clock)
//   rst_n         : async active-low reset
//   button_in     : raw button pins, one bit per channel
//   btn_level     : debounced levels, 1 = pressed
//   click_pulse   : 1-cycle pulse per channel on release of a short press
//   long_pulse    : 1-cycle pulse per channel when the long time is reached
//   repeat_pulse  : 1-cycle pulse per channel every repeat period past long
//   dbg_state     : 3-bit FSM state per channel, channel g at [3g+2:3g]
// -----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int CLK_HZ      = 125_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 3000,
    parameter int REPEAT_MS   = 200,
    parameter int REPEAT_EN   = 1,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [N_BTN-1:0]   button_in,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   click_pulse,
    output logic [N_BTN-1:0]   long_pulse,
    output logic [N_BTN-1:0]   repeat_pulse,
    output logic [3*N_BTN-1:0] dbg_state
);

    localparam int TPM = ticks_per_ms(CLK_HZ);
    localparam int PW  = (TPM > 1) ? $clog2(TPM) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TPM - 1);

    logic [PW-1:0] pre_q;
    logic          tick_q;

    // Registered strobe: high for one cycle every TPM cycles.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else if (pre_q == PRE_LAST) begin
            pre_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            pre_q  <= pre_q + PW'(1);
            tick_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .REPEAT_MS   (REPEAT_MS),
            .REPEAT_EN   (REPEAT_EN),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .tick_i   (tick_q),
            .button_i (button_in[g]),
            .level_o  (btn_level[g]),
            .click_o  (click_pulse[g]),
            .long_o   (long_pulse[g]),
            .repeat_o (repeat_pulse[g]),
            .state_o  (dbg_state[3*g +: 3])
        );
    end

endmodule
